fnd_scan_controller: RTL and testbench

FND_SCAN_CONTROLLER -- requirements
Module: fnd_scan_controller

---
 rtl/fnd_scan_controller.sv | 118 +++++++++++
 tb/tb_fnd_scan_controller.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/fnd_scan_controller.sv
// Four-digit multiplexed FND driver: scans digits, snapshots time fields
// once per frame and blinks the centre dot at 1 Hz.
module fnd_scan_controller #(
    parameter int BIT_100HZ = 100,
    parameter int SECOND_60 = 60,
    parameter int HOUR      = 24,
    parameter int SCAN_DIV  = 100_000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         disp_mode,
    input  logic [$clog2(BIT_100HZ)-1:0] msec,
    input  logic [$clog2(SECOND_60)-1:0] sec,
    input  logic [$clog2(SECOND_60)-1:0] min,
    input  logic [$clog2(HOUR)-1:0]      hour,
    input  logic                         tick_100hz,
    output logic [3:0]                   fnd_comm,
    output logic [7:0]                   fnd_font
);

    localparam int MS_W = $clog2(BIT_100HZ);
    localparam int SM_W = $clog2(SECOND_60);
    localparam int HR_W = $clog2(HOUR);
    localparam int SC_W = $clog2(SCAN_DIV);

    logic [SC_W-1:0] scan_cnt;
    logic [1:0]      digit_idx;
    logic [5:0]      tick_cnt;
    logic            blink;

    logic            snap_mode;
    logic [MS_W-1:0] snap_msec;
    logic [SM_W-1:0] snap_sec;
    logic [SM_W-1:0] snap_min;
    logic [HR_W-1:0] snap_hour;

    logic scan_wrap;
    logic frame_wrap;

    assign scan_wrap  = (scan_cnt == SC_W'(SCAN_DIV - 1));
    assign frame_wrap = scan_wrap && (digit_idx == 2'd3);

    function automatic logic [7:0] seg(input logic [3:0] d);
        unique case (d)
            4'd0:    seg = 8'hC0;
            4'd1:    seg = 8'hF9;
            4'd2:    seg = 8'hA4;
            4'd3:    seg = 8'hB0;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h92;
            4'd6:    seg = 8'h82;
            4'd7:    seg = 8'hF8;
            4'd8:    seg = 8'h80;
            4'd9:    seg = 8'h90;
            default: seg = 8'hBF;
        endcase
    endfunction

    int unsigned field;
    int unsigned limit;
    int unsigned digit;
    logic [3:0]  comm_next;
    logic [7:0]  font_next;

    // Digits 0/1 show the low field, digits 2/3 the high field.
    always_comb begin
        field = 0;
        limit = 0;
        unique case ({snap_mode, digit_idx[1]})
            2'b00: begin field = 32'(snap_msec); limit = BIT_100HZ; end
            2'b01: begin field = 32'(snap_sec);  limit = SECOND_60; end
            2'b10: begin field = 32'(snap_min);  limit = SECOND_60; end
            default: begin field = 32'(snap_hour); limit = HOUR; end
        endcase
        digit     = digit_idx[0] ? (field / 10) : (field % 10);
        font_next = (field >= limit) ? 8'hBF : seg(4'(digit));
        font_next[7] = ~(blink && (digit_idx == 2'd2));
        comm_next = ~(4'b0001 << digit_idx);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
            tick_cnt  <= '0;
            blink     <= 1'b0;
            snap_mode <= 1'b0;
            snap_msec <= '0;
            snap_sec  <= '0;
            snap_min  <= '0;
            snap_hour <= '0;
            fnd_comm  <= 4'b1110;
            fnd_font  <= 8'hC0;
        end else begin
            scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
            if (scan_wrap)
                digit_idx <= digit_idx + 2'd1;
            if (frame_wrap) begin
                snap_mode <= disp_mode;
                snap_msec <= msec;
                snap_sec  <= sec;
                snap_min  <= min;
                snap_hour <= hour;
            end
            if (tick_100hz) begin
                if (tick_cnt == 6'd49) begin
                    tick_cnt <= '0;
                    blink    <= ~blink;
                end else begin
                    tick_cnt <= tick_cnt + 6'd1;
                end
            end
            fnd_comm <= comm_next;
            fnd_font <= font_next;
        end
    end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Scoreboard bench: a frame-level reference model queues the expected
// display word per cycle, a monitor pops and compares after each edge.
module tb_fnd_scan_controller;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       disp_mode;
    logic [6:0] msec;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic       tick_100hz;
    logic [3:0] fnd_comm;
    logic [7:0] fnd_font;

    int n_checks = 0;
    int n_fail   = 0;

    logic [11:0] exp_q[$];

    fnd_scan_controller #(.SCAN_DIV(S)) dut (
        .clk        (clk),
        .reset      (reset),
        .disp_mode  (disp_mode),
        .msec       (msec),
        .sec        (sec),
        .min        (min),
        .hour       (hour),
        .tick_100hz (tick_100hz),
        .fnd_comm   (fnd_comm),
        .fnd_font   (fnd_font)
    );

    always #5 clk = ~clk;

    logic [7:0] font_tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                  8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    // Reference model: cycle count since reset, total ticks, frame snapshot.
    int k = 0;
    int ticks = 0;
    int m_mode, m_ms, m_sec, m_min, m_hr;

    function automatic logic [7:0] pair_font(int v, int lim, int pos);
        if (v >= lim) return 8'hBF;
        return font_tbl[(pos == 0) ? (v % 10) : (v / 10)];
    endfunction

    always @(posedge clk) begin
        int idx, blk;
        logic [7:0] f;
        if (reset) begin
            k = 0; ticks = 0;
            m_mode = 0; m_ms = 0; m_sec = 0; m_min = 0; m_hr = 0;
            exp_q.push_back({4'b1110, 8'hC0});
        end else begin
            k++;
            idx = ((k - 1) / S) % 4;
            blk = (ticks / 50) % 2;
            if (m_mode == 0)
                f = (idx < 2) ? pair_font(m_ms, 100, idx % 2)
                              : pair_font(m_sec, 60, idx % 2);
            else
                f = (idx < 2) ? pair_font(m_min, 60, idx % 2)
                              : pair_font(m_hr, 24, idx % 2);
            f[7] = !(blk == 1 && idx == 2);
            exp_q.push_back({~(4'b0001 << idx), f});
            if (tick_100hz) ticks++;
            if (k % (4 * S) == 0) begin
                m_mode = disp_mode; m_ms = msec; m_sec = sec;
                m_min = min; m_hr = hour;
            end
        end
    end

    always @(posedge clk) begin
        logic [11:0] e;
        #1;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL queue_empty t=%0t got comm=%b font=%h", $time,
                     fnd_comm, fnd_font);
        end else begin
            e = exp_q.pop_front();
            if ({fnd_comm, fnd_font} !== e) begin
                n_fail++;
                $display("FAIL display t=%0t got comm=%b font=%h exp comm=%b font=%h",
                         $time, fnd_comm, fnd_font, e[11:8], e[7:0]);
            end
        end
    end

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ticks_for(int n);
        repeat (n) begin
            tick_100hz = 1'b1;
            @(negedge clk);
        end
        tick_100hz = 1'b0;
    endtask

    initial begin
        reset = 1'b1; disp_mode = 1'b0; msec = '0; sec = '0;
        min = '0; hour = '0; tick_100hz = 1'b0;
        step(2);
        reset = 1'b0;
        msec = 7'd47; sec = 6'd35;
        step(4 * S + 4 * S + 6);
        disp_mode = 1'b1; hour = 5'd23; min = 6'd9;
        step(4 * S * 2);
        disp_mode = 1'b0; msec = 7'd47; sec = 6'd35;
        ticks_for(50);
        step(4 * S * 2);
        ticks_for(50);
        step(4 * S);
        sec = 6'd60; msec = 7'd5;
        step(4 * S * 2);
        ticks_for(50);
        step(2 * S + 1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(4 * S * 2);
        // Tick exactly on the 3->0 wrap edge is covered by the continuous burst.
        ticks_for(4 * S * 3 + 3);
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                disp_mode = 1'($urandom_range(0, 1));
                msec = 7'($urandom_range(0, 127));
                sec  = 6'($urandom_range(0, 63));
                min  = 6'($urandom_range(0, 63));
                hour = 5'($urandom_range(0, 31));
            end
            tick_100hz = ($urandom_range(0, 2) != 0);
            reset = ($urandom_range(0, 399) == 0);
            step(1);
        end
        reset = 1'b0; tick_100hz = 1'b0;
        step(3);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
